// File: rtl/hlsm_shared_alu_sched.sv
// hlsm_shared_alu_sched: shared-ALU HLSM computing z = (a+b > a+c) ? low(a+b) : low(a+c) and x = a*c - (a+b)
// Optional macro SIGNED_COMPARE_EN: when defined, the d > e compare is two's-complement signed.
module hlsm_shared_alu_sched #(
   parameter int DATAWIDTH = 16,
   parameter int ZWIDTH    = 8,
   parameter int MUL_LAT   = 2
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 Start,
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   input  logic [DATAWIDTH-1:0] c,
   output logic                 Done,
   output logic                 Busy,
   output logic [ZWIDTH-1:0]    z,
   output logic [DATAWIDTH-1:0] x
);
   typedef enum logic [2:0] {WAIT, S1, S2, S3, MWAIT, S4, FINAL} state_t;
   state_t               r_state, w_next;
   logic [DATAWIDTH-1:0] r_a, r_b, r_c, r_d, r_e, r_x;
   logic [ZWIDTH-1:0]    r_z;
   logic                 r_g;
   logic [3:0]           r_cnt;
   logic [DATAWIDTH-1:0] r_mp [1:MUL_LAT];
   logic [DATAWIDTH-1:0] w_prod, w_f, w_alu_a, w_alu_b, w_alu_y;
   logic                 w_gt, w_f_ready;
   assign w_prod    = r_a * r_c;
   assign w_f       = r_mp[MUL_LAT];
   assign w_f_ready = r_cnt >= 4'(MUL_LAT - 1);
   assign z         = r_z;
   assign x         = r_x;
   // State register
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) r_state <= WAIT;
      else     r_state <= w_next;
   end
   // Next-state and handshake outputs; S3/MWAIT advance once f lands at the coming edge
   always_comb begin
      w_next = r_state;
      Done   = 1'b0;
      Busy   = 1'b1;
      case (r_state)
         WAIT:    begin Busy = 1'b0; w_next = Start ? S1 : WAIT; end
         S1:      w_next = S2;
         S2:      w_next = S3;
         S3:      w_next = w_f_ready ? S4 : MWAIT;
         MWAIT:   w_next = w_f_ready ? S4 : MWAIT;
         S4:      w_next = FINAL;
         FINAL:   begin Done = 1'b1; w_next = WAIT; end
         default: w_next = WAIT;
      endcase
   end
   // Shared ALU operand steering: one add/sub/compare per state
   always_comb begin
      w_alu_a = (r_state == S3) ? r_d : (r_state == S4) ? w_f : r_a;
      w_alu_b = (r_state == S1) ? r_b : (r_state == S2) ? r_c : (r_state == S3) ? r_e : r_d;
      w_alu_y = (r_state == S4) ? w_alu_a - w_alu_b : w_alu_a + w_alu_b;
   end
`ifdef SIGNED_COMPARE_EN
   assign w_gt = $signed(w_alu_a) > $signed(w_alu_b);
`else
   assign w_gt = w_alu_a > w_alu_b;
`endif
   // Operand capture, ALU result registers and cycle count since issue
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_a   <= '0;
         r_b   <= '0;
         r_c   <= '0;
         r_d   <= '0;
         r_e   <= '0;
         r_g   <= 1'b0;
         r_z   <= '0;
         r_x   <= '0;
         r_cnt <= '0;
      end else begin
         r_cnt <= (r_state == WAIT) ? 4'd0 : r_cnt + 4'd1;
         if (r_state == WAIT && Start) begin
            r_a <= a;
            r_b <= b;
            r_c <= c;
         end
         if (r_state == S1) r_d <= w_alu_y;
         if (r_state == S2) r_e <= w_alu_y;
         if (r_state == S3) r_g <= w_gt;
         if (r_state == S4) begin
            r_x <= w_alu_y;
            r_z <= r_g ? r_d[ZWIDTH-1:0] : r_e[ZWIDTH-1:0];
         end
      end
   end
   // Multiplier pipe; operands only change on capture, so f is stable MUL_LAT edges after S1 starts
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         for (int i = 1; i <= MUL_LAT; i++) r_mp[i] <= '0;
      end else begin
         r_mp[1] <= w_prod;
         for (int i = 2; i <= MUL_LAT; i++) r_mp[i] <= r_mp[i-1];
      end
   end
endmodule

// File: tb/tb_hlsm_shared_alu_sched.sv
// tb_hlsm_shared_alu_sched: randomized self-checking bench against a formula-level reference model
module tb_hlsm_shared_alu_sched;
   localparam int ML  = 2;
   localparam int LAT = 5 + ((ML > 3) ? ML - 3 : 0);
   logic        Clk = 1'b0, Rst = 1'b1, Start = 1'b0;
   logic [15:0] a = '0, b = '0, c = '0;
   logic        Done, Busy;
   logic [7:0]  z;
   logic [15:0] x;
   int          n_cmp = 0, n_bad = 0;
   hlsm_shared_alu_sched #(.DATAWIDTH(16), .ZWIDTH(8), .MUL_LAT(ML)) dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .a(a), .b(b), .c(c),
      .Done(Done), .Busy(Busy), .z(z), .x(x)
   );
   always #5 Clk = ~Clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask
   // Returns {z, x} straight from the defining formulas
   function automatic logic [23:0] model(input logic [15:0] ia, input logic [15:0] ib, input logic [15:0] ic);
      logic [15:0] d, e, f, xv;
      logic        g;
      d = ia + ib;
      e = ia + ic;
      f = ia * ic;
`ifdef SIGNED_COMPARE_EN
      g = $signed(d) > $signed(e);
`else
      g = d > e;
`endif
      xv = f - d;
      return {g ? d[7:0] : e[7:0], xv};
   endfunction
   // One computation; xs names the cycle after the Start edge that carries a stray Start (0 = none)
   task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic [15:0] ic, input int xs);
      logic [23:0] m;
      int          done_cyc, n_done, n_busy;
      m = model(ia, ib, ic);
      done_cyc = 0;
      n_done = 0;
      n_busy = 0;
      @(negedge Clk);
      a = ia; b = ib; c = ic; Start = 1'b1;
      @(negedge Clk);
      for (int k = 1; k <= LAT + 3; k++) begin
         if (Done) begin
            n_done++;
            if (done_cyc == 0) done_cyc = k;
         end
         if (Busy) n_busy++;
         Start = (k == xs);
         a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
         @(negedge Clk);
      end
      Start = 1'b0;
      check("done_cycle", done_cyc, LAT);
      check("done_count", n_done, 1);
      check("busy_cycles", n_busy, LAT);
      check("z", {24'd0, z}, {24'd0, m[23:16]});
      check("x", {16'd0, x}, {16'd0, m[15:0]});
   endtask
   initial begin
      int          n_done, second, sel;
      logic [23:0] m;
      repeat (2) @(negedge Clk);
      check("rst_done", Done, 0);
      check("rst_busy", Busy, 0);
      check("rst_z", z, 0);
      check("rst_x", x, 0);
      Rst = 1'b0;
      run_op(16'd10, 16'd20, 16'd5, 0);
      check("basic_z_const", z, 30);
      check("basic_x_const", x, 20);
      run_op(16'hFFFF, 16'd2, 16'd1, 0);
      check("wrap_x_const", x, 16'hFFFE);
      run_op(16'h7FFF, 16'h0005, 16'h8002, 0);
      check("sign_x_const", x, 16'hFFFA);
      run_op(16'd3, 16'd4, 16'd9, 2);
      run_op(16'd1000, 16'd7, 16'd300, LAT);
      // Asynchronous reset during S3
      @(negedge Clk);
      a = 16'd50; b = 16'd60; c = 16'd70; Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      repeat (2) @(negedge Clk);
      #2 Rst = 1'b1;
      #1;
      check("abort_busy", Busy, 0);
      check("abort_done", Done, 0);
      check("abort_z", z, 0);
      check("abort_x", x, 0);
      @(negedge Clk);
      Rst = 1'b0;
      n_done = 0;
      repeat (LAT + 2) begin
         if (Done) n_done++;
         @(negedge Clk);
      end
      check("abort_no_done", n_done, 0);
      run_op(16'h1234, 16'h0F0F, 16'h00A5, 0);
      // Start held high: back-to-back computations every LAT+1 cycles
      @(negedge Clk);
      a = 16'd10; b = 16'd20; c = 16'd5; Start = 1'b1;
      @(negedge Clk);
      n_done = 0;
      second = 0;
      for (int k = 1; k <= 2 * LAT + 2; k++) begin
         if (Done) begin
            n_done++;
            if (k > LAT) second = k;
         end
         @(negedge Clk);
      end
      Start = 1'b0;
      repeat (LAT + 2) @(negedge Clk);
      check("b2b_done_count", n_done, 2);
      check("b2b_second_done", second, 2 * LAT + 1);
      m = model(16'd10, 16'd20, 16'd5);
      check("b2b_z", z, {24'd0, m[23:16]});
      check("b2b_x", x, {16'd0, m[15:0]});
      for (int i = 0; i < 20; i++) begin
         sel = $urandom_range(0, 2);
         run_op(16'($urandom), 16'($urandom), 16'($urandom), (sel == 0) ? 0 : (sel == 1) ? 2 : LAT);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/hlsm_shared_alu_sched.md
Name: hlsm_shared_alu_sched

Overview:
Resource-constrained HLSM controller for the z/x datapath (d=a+b, e=a+c, g=d>e, z=g?d:e, f=a*c, x=f-d).
- The team's direct-instantiation variant uses three adders, a comparator and a multiplier. This block shares one ALU (add/sub/compare) and one pipelined multiplier across all operations, scheduled over fixed states.
- Interface follows the standard HLSM contract: Clk, Rst, Start, Done.
- Used where area matters more than latency.

Parameters:
DATAWIDTH, 16, width of a, b, c, x, and of internal registers d, e, f
ZWIDTH, 8, width of z, which takes the low bits of the selected value
MUL_LAT, 2, multiplier pipeline latency in cycles; legal range 1..6

Ports:
Clk  input  1  rising-edge clock
Rst  input  1  asynchronous reset, active-high
Start  input  1  level-sampled request to begin a computation
a  input  DATAWIDTH  operand a, captured on accepted Start
b  input  DATAWIDTH  operand b, captured on accepted Start
c  input  DATAWIDTH  operand c, captured on accepted Start
Done  output  1  one-cycle pulse when z and x are valid
Busy  output  1  high from S1 through FINAL inclusive
z  output  ZWIDTH  result z = g ? d[ZWIDTH-1:0] : e[ZWIDTH-1:0]
x  output  DATAWIDTH  result x = f - d

Behaviour:
Reset:
- Rst=1 forces state=WAIT; Done, Busy, z, x and all internal registers (ra, rb, rc, d, e, f, g, mul pipe) go to 0.
- Reset mid-operation aborts the computation. No Done is produced.

States: WAIT, S1, S2, S3, MWAIT, S4, FINAL.
- WAIT: Start=1 at a clock edge captures a, b, c into ra, rb, rc and moves to S1. Start=0 stays in WAIT.
- S1: ALU d <= ra+rb. Multiplier issued with ra*rc.
- S2: ALU e <= ra+rc.
- S3: ALU g <= (d > e), unsigned. Go to S4 if the multiplier result is valid by the next edge, otherwise go to MWAIT.
- MWAIT: stall only. Stays until the multiplier result f is registered. Entered only when MUL_LAT > 3, for exactly MUL_LAT-3 cycles.
- S4: ALU x <= f - d. z <= g ? d[ZWIDTH-1:0] : e[ZWIDTH-1:0].
- FINAL: Done=1 for exactly this one cycle, then return to WAIT.

Multiplier timing:
- Result f is registered MUL_LAT cycles after issue in S1.

Latency:
- The Start edge moves WAIT→S1.
- Done is high in the 5th cycle after that edge when MUL_LAT ≤ 3.
- Done is high in the (5+MUL_LAT-3)th cycle otherwise.

Arithmetic:
- Unsigned, modulo 2^DATAWIDTH. Carries and the high product bits are discarded.
- z is truncated to ZWIDTH.

Handshake rules:
- Start while Busy=1 is ignored. Operands are not re-captured and there is no queueing.
- Start=1 in the FINAL cycle is ignored.
- Start held high continuously restarts from WAIT. Back-to-back throughput is therefore 1 computation per (latency+1) cycles.
- z and x hold their values after Done until overwritten by the S4 of the next computation.
- Input changes after capture have no effect on the current computation.

ALU rule:
- Exactly one ALU operation per state. A bench monitor must never see two ALU ops in the same cycle.

Optional Feature:
Macro SIGNED_COMPARE_EN.
- Defined: the S3 compare treats d and e as two's-complement signed values.
- Not defined: the compare is unsigned.
- The add, sub and multiply operations are identical either way.

Test Plan:
- Basic, MUL_LAT=2: reset, then a=10, b=20, c=5, Start for 1 cycle -> Done pulse in 5th cycle after the Start edge; z=30, x=20 (d=30, e=15, f=50); Busy high for 5 cycles.
- Wrap: a=0xFFFF, b=2, c=1 -> d=1, e=0, g=1, z=0x01, f=0xFFFF, x=0xFFFE.
- Compare sign, a=0x7FFF, b=0x0005, c=0x8002, results depend on SIGNED_COMPARE_EN:
  - undefined: z=0x04
  - defined: z=0x01
  - x=0xFFFA in both builds
- Start re-asserted in S2 with different operands -> ignored; results match the first operand set; exactly one Done.
- Rst asserted asynchronously during S3 -> immediate state=WAIT; z=x=0, Busy=0; no Done; a new Start afterwards gives correct results.
- MUL_LAT=5 build, vector from the first scenario -> 2 MWAIT cycles; Done in 7th cycle after the Start edge; z=30, x=20.
